mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

MEM-stage data-memory access unit plus MEM/WB pipeline register for the 5-stage pipeline. Consumes the outputs of the EXE/MEM register, runs loads and stores against data memory over a req/ack handshake, stalls upstream during wait states, and registers the selected writeback result into WB. Non-memory instructions pass through with one cycle of latency.

## Interface
- `TIMEOUT_CYCLES`, 16: WAIT cycles before an access is aborted (used only with `MEM_TIMEOUT_EN`); range 1..255.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset (sampled on `clk`; `rst`=0 resets).
- `mem_sw_o`  in  32  store data.
- `mem_write_o`  in  32  mov operand (writeback candidate).
- `mem_alu_result`  in  32  ALU result / data-memory byte address.
- `mem_lwsrc`  in  1  1 = writeback from load data, 0 = from ALU result.
- `mem_movsrc`  in  1  1 = writeback from `mem_write_o` (overrides `mem_lwsrc`).
- `mem_DM_read`  in  1  load request.
- `mem_DM_write`  in  1  store request.
- `mem_wen`  in  1  register write enable; 0 with no DM op = bubble.
- `mem_waddr`  in  5  destination GPR.
- `dm_req`  out  1  memory request.
- `dm_we`  out  1  1 = store.
- `dm_addr`  out  32  equals `mem_alu_result`.
- `dm_wdata`  out  32  equals `mem_sw_o`.
- `dm_ack`  in  1  access complete; `dm_rdata` valid in the same cycle.
- `dm_rdata`  in  32  load data.
- `mem_stall`  out  1  hold IF..EXE/MEM stages.
- `mem_bus_err`  out  1  one-cycle pulse on access abort.
- `wb_wen`, `wb_waddr`, `wb_data`  out  1/5/32  registered writeback.

## Operation
- Memory op: `op = mem_DM_read | mem_DM_write`. If both are set, the access is a store and the read is ignored.
- Result mux: `movsrc ? mem_write_o : (lwsrc ? dm_rdata : mem_alu_result)`.
- FSM states are IDLE and WAIT.
  - **IDLE, op=0:** `dm_req`=0 and `mem_stall`=0. WB loads `{mem_wen, mem_waddr, mux}`.
  - **IDLE, op=1:** `dm_req`=1 and `dm_we`=`mem_DM_write`.
    - With `dm_ack`=1: no stall; WB loads the result and the FSM stays in IDLE.
    - With `dm_ack`=0: `mem_stall`=1, WB loads a bubble (`wb_wen`=0), and the FSM goes to WAIT.
  - **WAIT:** `dm_req` is held at 1. Address and data stay stable because upstream is stalled.
    - With `dm_ack`=1: `mem_stall`=0, WB loads the result, and the FSM goes to IDLE.
    - Otherwise: stall and WB bubble continue.
- `dm_req`, `dm_we` and `mem_stall` are combinational from state and inputs. All are forced to 0 while `rst`=0.
- A store writes back only if `mem_wen`=1, so store→WB is normally a bubble.

## Timing
- Reset values: state IDLE, wait counter 0, `wb_wen`=0, `wb_waddr`=0, `wb_data`=0, `mem_bus_err`=0.
- Latency:
  - Non-memory op: 1 cycle to WB.
  - Zero-wait access (ack in the first cycle): 1 cycle.
  - N wait states: N+1 cycles, with `mem_stall` high for exactly N cycles.
- WB loads exactly once per instruction. During stall, bubbles prevent a double write.
- Back-to-back accesses: the next op is presented in the cycle after an ack. No idle cycle is required.
- Reset asserted during WAIT: the FSM returns to IDLE at the next edge. Any later `dm_ack` while in IDLE with op=0 is ignored.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit counter increments each WAIT cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, the access is aborted: `dm_req`=0 and `mem_stall`=0 that cycle, the FSM returns to IDLE, and WB loads a bubble.
  - `mem_bus_err`=1 for the next cycle. The counter clears.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no error.
- Undefined: WAIT persists until ack, the counter is not instantiated, and `mem_bus_err` is tied 0.

## Structure
- Shared package `pipe_pkg`:
  - FSM state enum `mem_state_e`.
  - `REG_W`=32 and `RADDR_W`=5.
  - Writeback-source encodings (`LW_MEM_SRC`=1, `MV_OP_SRC`=1).
- Sub-module `mem_dm_ctrl`: FSM, timeout counter, and `dm_*`/`mem_stall` generation.
- Top-level: result mux and MEM/WB register.

## Test plan
- ALU op `alu_result`=0x0000_0010, `wen`=1, `waddr`=3, no DM op -> next cycle `wb_wen`=1, `wb_waddr`=3, `wb_data`=0x10; `mem_stall` never high.
- Load addr 0x100, `lwsrc`=1, `dm_ack` after 3 wait cycles with rdata 0xDEAD_BEEF -> `mem_stall` high 3 cycles, `dm_req` high 4 cycles; single `wb_wen` pulse with `wb_data`=0xDEAD_BEEF.
- Store addr 0x200, data 0x1234, read+write both set, zero-wait ack -> `dm_we`=1, `dm_wdata`=0x1234, no stall; `wb_wen`=0 when `mem_wen`=0.
- `movsrc`=1, `write_o`=0x55, `lwsrc`=1 -> `wb_data`=0x55.
- With `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, load never acked -> stall drops on the 4th WAIT cycle, `mem_bus_err` pulses once, `wb_wen`=0. Without the macro -> stall held indefinitely.
- `rst`=0 for one cycle during WAIT -> next cycle state IDLE, `dm_req`=0, all WB outputs 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the MEM/WB slice: widths, writeback-source
// encodings, the data-memory FSM state type and the writeback result mux.
package pipe_pkg;

   localparam int unsigned REG_W   = 32;
   localparam int unsigned RADDR_W = 5;

   // Writeback-source select encodings
   localparam logic LW_MEM_SRC = 1'b1;
   localparam logic MV_OP_SRC  = 1'b1;

   typedef enum logic [0:0] {
      StIdle,
      StWait
   } mem_state_e;

   typedef struct packed {
      logic               wen;
      logic [RADDR_W-1:0] waddr;
      logic [REG_W-1:0]   data;
   } wb_entry_t;

   // mov operand overrides load data, which overrides the ALU result
   function automatic logic [REG_W-1:0] wb_mux(input logic             movsrc,
                                              input logic             lwsrc,
                                              input logic [REG_W-1:0] write_o,
                                              input logic [REG_W-1:0] rdata,
                                              input logic [REG_W-1:0] alu);
      if (movsrc == MV_OP_SRC) return write_o;
      if (lwsrc == LW_MEM_SRC) return rdata;
      return alu;
   endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
interface mem_wb_stage_if;
   import pipe_pkg::*;

   logic             dm_req;
   logic             dm_we;
   logic [REG_W-1:0] dm_addr;
   logic [REG_W-1:0] dm_wdata;
   logic             dm_ack;
   logic [REG_W-1:0] dm_rdata;

   modport master (
      output dm_req,
      output dm_we,
      output dm_addr,
      output dm_wdata,
      input  dm_ack,
      input  dm_rdata
   );

   modport slave (
      input  dm_req,
      input  dm_we,
      input  dm_addr,
      input  dm_wdata,
      output dm_ack,
      output dm_rdata
   );

endinterface

// File: rtl/mem_dm_ctrl.sv
// Data-memory access controller: IDLE/WAIT FSM, optional wait timeout and
// generation of dm_req/dm_we/mem_stall.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES
// unacknowledged WAIT cycles and pulse mem_bus_err.
module mem_dm_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_DM_read,
   input  logic mem_DM_write,
   input  logic dm_ack,
   output logic dm_req,
   output logic dm_we,
   output logic mem_stall,
   output logic abort,
   output logic mem_bus_err
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_cfg_check
      $error("mem_dm_ctrl: TIMEOUT_CYCLES must be in 1..255");
   end

   mem_state_e state_q, state_d;
   logic       op;
   logic       timeout_hit;

   assign op = mem_DM_read | mem_DM_write;

`ifdef MEM_TIMEOUT_EN
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       bus_err_q;

   // Fires on the TIMEOUT_CYCLES-th WAIT cycle still lacking an ack
   assign timeout_hit = (state_q == StWait) && (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));
   assign mem_bus_err = bus_err_q;

   // Count unacknowledged WAIT cycles; cleared on completion, abort or leaving WAIT
   always_comb begin
      wait_cnt_d = '0;
      if (state_q == StWait && !dm_ack && !timeout_hit) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end
   end

   // Timeout counter and one-cycle bus error pulse following an abort
   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt_q <= '0;
         bus_err_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         bus_err_q  <= abort;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign mem_bus_err = 1'b0;
`endif

   // Next state and handshake outputs; everything held low while in reset
   always_comb begin
      state_d   = state_q;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      mem_stall = 1'b0;
      abort     = 1'b0;
      if (rst) begin
         unique case (state_q)
            StIdle: begin
               if (op) begin
                  dm_req = 1'b1;
                  dm_we  = mem_DM_write;
                  if (!dm_ack) begin
                     mem_stall = 1'b1;
                     state_d   = StWait;
                  end
               end
            end
            StWait: begin
               if (dm_ack) begin
                  dm_req  = 1'b1;
                  dm_we   = mem_DM_write;
                  state_d = StIdle;
               end else if (timeout_hit) begin
                  abort   = 1'b1;
                  state_d = StIdle;
               end else begin
                  dm_req    = 1'b1;
                  dm_we     = mem_DM_write;
                  mem_stall = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) state_q <= StIdle;
      else      state_q <= state_d;
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB register: drives the data-memory bus, selects the
// writeback result and registers it, inserting bubbles while an access waits.
// Optional feature: MEM_TIMEOUT_EN (see mem_dm_ctrl) enables access timeout.
module mem_wb_stage
   import pipe_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [REG_W-1:0]   mem_sw_o,
   input  logic [REG_W-1:0]   mem_write_o,
   input  logic [REG_W-1:0]   mem_alu_result,
   input  logic               mem_lwsrc,
   input  logic               mem_movsrc,
   input  logic               mem_DM_read,
   input  logic               mem_DM_write,
   input  logic               mem_wen,
   input  logic [RADDR_W-1:0] mem_waddr,
   mem_wb_stage_if.master     dm,
   output logic               mem_stall,
   output logic               mem_bus_err,
   output logic               wb_wen,
   output logic [RADDR_W-1:0] wb_waddr,
   output logic [REG_W-1:0]   wb_data
);

   logic             abort;
   logic [REG_W-1:0] result;
   wb_entry_t        wb_q, wb_d;

   mem_dm_ctrl #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_dm_ctrl (
      .clk          (clk),
      .rst          (rst),
      .mem_DM_read  (mem_DM_read),
      .mem_DM_write (mem_DM_write),
      .dm_ack       (dm.dm_ack),
      .dm_req       (dm.dm_req),
      .dm_we        (dm.dm_we),
      .mem_stall    (mem_stall),
      .abort        (abort),
      .mem_bus_err  (mem_bus_err)
   );

   // Address and data come straight from EXE/MEM; upstream stall keeps them stable
   assign dm.dm_addr  = mem_alu_result;
   assign dm.dm_wdata = mem_sw_o;

   assign result = wb_mux(mem_movsrc, mem_lwsrc, mem_write_o, dm.dm_rdata, mem_alu_result);

   // Load the instruction only in its completing cycle; otherwise insert a bubble
   always_comb begin
      wb_d = '0;
      if (!mem_stall && !abort) begin
         wb_d = '{wen: mem_wen, waddr: mem_waddr, data: result};
      end
   end

   // MEM/WB pipeline register
   always_ff @(posedge clk) begin
      if (!rst) wb_q <= '0;
      else      wb_q <= wb_d;
   end

   assign wb_wen   = wb_q.wen;
   assign wb_waddr = wb_q.waddr;
   assign wb_data  = wb_q.data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: expected writebacks are queued when an
// instruction is driven and compared when wb_wen pulses.
module tb_mem_wb_stage;
   import pipe_pkg::*;

   localparam int unsigned TO_CYC = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [REG_W-1:0]   mem_sw_o, mem_write_o, mem_alu_result;
   logic               mem_lwsrc, mem_movsrc, mem_DM_read, mem_DM_write, mem_wen;
   logic [RADDR_W-1:0] mem_waddr;
   logic               mem_stall, mem_bus_err, wb_wen;
   logic [RADDR_W-1:0] wb_waddr;
   logic [REG_W-1:0]   wb_data;

   mem_wb_stage_if dm_bus ();

   mem_wb_stage #(
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_sw_o       (mem_sw_o),
      .mem_write_o    (mem_write_o),
      .mem_alu_result (mem_alu_result),
      .mem_lwsrc      (mem_lwsrc),
      .mem_movsrc     (mem_movsrc),
      .mem_DM_read    (mem_DM_read),
      .mem_DM_write   (mem_DM_write),
      .mem_wen        (mem_wen),
      .mem_waddr      (mem_waddr),
      .dm             (dm_bus),
      .mem_stall      (mem_stall),
      .mem_bus_err    (mem_bus_err),
      .wb_wen         (wb_wen),
      .wb_waddr       (wb_waddr),
      .wb_data        (wb_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int wb_pulses = 0;
   int exp_pulses = 0;
   logic [RADDR_W+REG_W-1:0] exp_q[$];
   logic [RADDR_W+REG_W-1:0] sb_exp;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every writeback pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst === 1'b1 && wb_wen === 1'b1) begin
         wb_pulses++;
         if (exp_q.size() == 0) begin
            check("wb_unexpected", 64'(wb_wen), 64'd0);
         end else begin
            sb_exp = exp_q.pop_front();
            check("wb_waddr", 64'(wb_waddr), 64'(sb_exp[REG_W +: RADDR_W]));
            check("wb_data", 64'(wb_data), 64'(sb_exp[REG_W-1:0]));
         end
      end
   end

   task automatic set_bubble();
      mem_sw_o       = '0;
      mem_write_o    = '0;
      mem_alu_result = '0;
      mem_lwsrc      = 1'b0;
      mem_movsrc     = 1'b0;
      mem_DM_read    = 1'b0;
      mem_DM_write   = 1'b0;
      mem_wen        = 1'b0;
      mem_waddr      = '0;
   endtask

   task automatic idle(input int n);
      set_bubble();
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one instruction (called at posedge+1) and act as memory that acks
   // after n_wait wait states. Returns at posedge+1 after the instruction retires.
   task automatic do_op(input string name, input logic [31:0] alu, input logic [31:0] wr_o,
                        input logic [31:0] sw, input logic lw, input logic mv,
                        input logic rd, input logic wr, input logic wen,
                        input logic [4:0] waddr, input int n_wait, input logic [31:0] rdata);
      int          stalls;
      int          reqs;
      logic        op;
      logic        accepted;
      logic [31:0] res;
      mem_alu_result = alu;
      mem_write_o    = wr_o;
      mem_sw_o       = sw;
      mem_lwsrc      = lw;
      mem_movsrc     = mv;
      mem_DM_read    = rd;
      mem_DM_write   = wr;
      mem_wen        = wen;
      mem_waddr      = waddr;
      op  = rd | wr;
      res = mv ? wr_o : (lw ? rdata : alu);
      if (wen) begin
         exp_q.push_back({waddr, res});
         exp_pulses++;
      end
      stalls   = 0;
      reqs     = 0;
      accepted = 1'b0;
      for (int cyc = 0; cyc < 64 && !accepted; cyc++) begin
         dm_bus.dm_ack   = op && (cyc == n_wait);
         dm_bus.dm_rdata = dm_bus.dm_ack ? rdata : (32'hBAD0_0000 | 32'(cyc));
         @(negedge clk);
         if (dm_bus.dm_req) begin
            reqs++;
            if (reqs == 1) begin
               check({name, "_dm_we"}, 64'(dm_bus.dm_we), 64'(wr));
               check({name, "_dm_addr"}, 64'(dm_bus.dm_addr), 64'(alu));
               check({name, "_dm_wdata"}, 64'(dm_bus.dm_wdata), 64'(sw));
            end
         end
         if (mem_stall) stalls++;
         else accepted = 1'b1;
         @(posedge clk);
         #1;
      end
      dm_bus.dm_ack = 1'b0;
      check({name, "_retired"}, 64'(accepted), 64'd1);
      check({name, "_stall_cycles"}, 64'(stalls), op ? 64'(n_wait) : 64'd0);
      check({name, "_req_cycles"}, 64'(reqs), op ? 64'(n_wait + 1) : 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int stalls;
      logic dropped;
      // Reset with a load pending: handshake outputs must stay low
      rst = 1'b0;
      set_bubble();
      mem_DM_read     = 1'b1;
      mem_wen         = 1'b1;
      mem_alu_result  = 32'h44;
      dm_bus.dm_ack   = 1'b0;
      dm_bus.dm_rdata = '0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_dm_req", 64'(dm_bus.dm_req), 64'd0);
      check("rst_stall", 64'(mem_stall), 64'd0);
      check("rst_wb_wen", 64'(wb_wen), 64'd0);
      check("rst_wb_waddr", 64'(wb_waddr), 64'd0);
      check("rst_wb_data", 64'(wb_data), 64'd0);
      check("rst_bus_err", 64'(mem_bus_err), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      set_bubble();

      do_op("alu", 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 0, 32'h0);
      do_op("load3", 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 3, 32'hDEAD_BEEF);
      do_op("store", 32'h200, 32'h0, 32'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 0, 32'h0);
      do_op("mov", 32'h77, 32'h55, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 0, 32'h0);
      do_op("mov_ld", 32'h80, 32'h66, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 1, 32'h99);
      // Back-to-back loads with no gap
      do_op("ld_b2b0", 32'h300, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd11, 0, 32'hCAFE_0001);
      do_op("ld_b2b1", 32'h304, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd12, 2, 32'hCAFE_0002);
      do_op("ld_b2b2", 32'h308, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd13, 0, 32'hCAFE_0003);
      do_op("st_wen", 32'h40C, 32'h0, 32'hABCD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd14, 1, 32'h0);
      do_op("alu2", 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 0, 32'h0);

      // Reset pulse while waiting on a load
      idle(1);
      mem_alu_result = 32'h500;
      mem_DM_read    = 1'b1;
      mem_lwsrc      = 1'b1;
      mem_wen        = 1'b1;
      mem_waddr      = 5'd20;
      @(negedge clk);
      check("rw_issue_stall", 64'(mem_stall), 64'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rw_wait_req", 64'(dm_bus.dm_req), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rw_rst_req", 64'(dm_bus.dm_req), 64'd0);
      check("rw_rst_stall", 64'(mem_stall), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      set_bubble();
      dm_bus.dm_ack = 1'b1;
      @(negedge clk);
      check("rw_idle_req", 64'(dm_bus.dm_req), 64'd0);
      check("rw_idle_stall", 64'(mem_stall), 64'd0);
      check("rw_wb_wen", 64'(wb_wen), 64'd0);
      check("rw_wb_waddr", 64'(wb_waddr), 64'd0);
      check("rw_wb_data", 64'(wb_data), 64'd0);
      @(posedge clk);
      #1;
      dm_bus.dm_ack = 1'b0;
      @(negedge clk);
      check("rw_stray_ack_wen", 64'(wb_wen), 64'd0);
      @(posedge clk);
      #1;
      do_op("alu_after_rst", 32'h21, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 0, 32'h0);

`ifdef MEM_TIMEOUT_EN
      // Never-acked load must be aborted on the TO_CYC-th WAIT cycle
      mem_alu_result = 32'h600;
      mem_DM_read    = 1'b1;
      mem_lwsrc      = 1'b1;
      mem_wen        = 1'b1;
      mem_waddr      = 5'd21;
      stalls  = 0;
      dropped = 1'b0;
      for (int cyc = 0; cyc < 32 && !dropped; cyc++) begin
         @(negedge clk);
         if (mem_stall) begin
            stalls++;
            if (mem_bus_err) check("to_err_early", 64'(mem_bus_err), 64'd0);
         end else begin
            dropped = 1'b1;
            check("to_abort_req", 64'(dm_bus.dm_req), 64'd0);
         end
         @(posedge clk);
         #1;
      end
      set_bubble();
      check("to_dropped", 64'(dropped), 64'd1);
      check("to_stall_cycles", 64'(stalls), 64'(TO_CYC));
      @(negedge clk);
      check("to_bus_err", 64'(mem_bus_err), 64'd1);
      check("to_wb_wen", 64'(wb_wen), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("to_bus_err_clear", 64'(mem_bus_err), 64'd0);
      @(posedge clk);
      #1;
      // Ack on the timeout cycle wins
      do_op("to_ack_race", 32'h700, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd22, TO_CYC,
            32'h1357_9BDF);
      @(negedge clk);
      check("to_race_no_err", 64'(mem_bus_err), 64'd0);
      @(posedge clk);
      #1;
      do_op("to_ld_short", 32'h704, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd23,
            TO_CYC - 1, 32'h2468_ACE0);
`else
      // Without timeout, a long wait just stalls until the ack arrives
      do_op("long_wait", 32'h800, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd24, 20,
            32'h0BAD_F00D);
      @(negedge clk);
      check("no_to_bus_err", 64'(mem_bus_err), 64'd0);
      @(posedge clk);
      #1;
`endif

      idle(3);
      check("sb_drained", 64'(exp_q.size()), 64'd0);
      check("wb_pulse_count", 64'(wb_pulses), 64'(exp_pulses));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
